control_unit: RTL and testbench

Hardwired Moore control sequencer for the single-bus CPU datapath. It steps through a four-cycle instruction fetch, decodes the 5-bit opcode in IR[31:27], and drives every datapath control strobe, one micro-step per clock. It replaces the per-cycle control vectors that testbenches currently supply by hand. It sits beside the datapath and sees only IR, the CON_FF result and two run-control inputs.

---
 rtl/control_unit.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_control_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer for the single-bus CPU datapath.
// Four-cycle fetch, opcode decode from IR[31:27], one micro-step per clock.
// The state register is the only storage; strobes decode from state and IR.
module control_unit (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        con_ff,
  input  logic        stop,
  output logic        run,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        HIout,
  output logic        LOout,
  output logic        Cout,
  output logic        MDR_out,
  output logic        InPort_Out,
  output logic        enableMAR,
  output logic        enableMDR,
  output logic        enableIR,
  output logic        enableY,
  output logic        enableZ,
  output logic        enablePC,
  output logic        enableHI,
  output logic        enableLO,
  output logic        enableInPort,
  output logic        enableOutPort,
  output logic        IncPC,
  output logic        Read,
  output logic        RAM_write_enable,
  output logic        conIn,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [4:0]  opcode
);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_JR   = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_MFHI = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_F0    = 4'd1,
    S_F1    = 4'd2,
    S_F2    = 4'd3,
    S_F3    = 4'd4,
    S_E0    = 4'd5,
    S_E1    = 4'd6,
    S_E2    = 4'd7,
    S_E3    = 4'd8,
    S_E4    = 4'd9,
    S_E5    = 4'd10,
    S_PAUSE = 4'd11,
    S_HALT  = 4'd12
  } state_t;

  state_t     state_q;
  state_t     state_d;
  state_t     done_s;
  logic [4:0] op_s;
  logic [2:0] e_idx_s;
  logic       exec_s;
  logic       last_s;
  logic       unused_ir_s;

  assign op_s        = IR[31:27];
  assign unused_ir_s = ^IR[26:0];

  // Number of execute steps each opcode occupies (unlisted codes behave as nop).
  function automatic logic [2:0] exec_len(input logic [4:0] op);
    case (op)
      OP_LD:                          exec_len = 3'd6;
      OP_ST:                          exec_len = 3'd5;
      OP_BR, OP_MUL, OP_DIV:          exec_len = 3'd4;
      OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR,
      OP_SHRA, OP_SHL, OP_ADDI, OP_ANDI, OP_ORI:
                                      exec_len = 3'd3;
      OP_NEG, OP_NOT, OP_JAL, OP_IN:  exec_len = 3'd2;
      default:                        exec_len = 3'd1;
    endcase
  endfunction

  // Execute-step index and detection of the final step of the instruction.
  always_comb begin
    exec_s  = 1'b1;
    e_idx_s = 3'd0;
    case (state_q)
      S_E0:    e_idx_s = 3'd0;
      S_E1:    e_idx_s = 3'd1;
      S_E2:    e_idx_s = 3'd2;
      S_E3:    e_idx_s = 3'd3;
      S_E4:    e_idx_s = 3'd4;
      S_E5:    e_idx_s = 3'd5;
      default: exec_s  = 1'b0;
    endcase
    last_s = exec_s && (e_idx_s == (exec_len(op_s) - 3'd1));
    done_s = stop ? S_PAUSE : S_F0;
  end

  // Next-state selection; stop is only honoured at instruction boundaries.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_F0;
      S_F0:    state_d = S_F1;
      S_F1:    state_d = S_F2;
      S_F2:    state_d = S_F3;
      S_F3:    state_d = S_E0;
      S_E0: begin
        if (op_s == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          state_d = last_s ? done_s : S_E1;
        end
      end
      S_E1:    state_d = last_s ? done_s : S_E2;
      S_E2:    state_d = last_s ? done_s : S_E3;
      S_E3:    state_d = last_s ? done_s : S_E4;
      S_E4:    state_d = last_s ? done_s : S_E5;
      S_E5:    state_d = done_s;
      S_PAUSE: state_d = stop ? S_PAUSE : S_F0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  // State register; clear forces RESET from any state, including HALT.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore strobe decode from the current step and the opcode held in IR.
  always_comb begin
    run = 1'b0; PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; HIout = 1'b0;
    LOout = 1'b0; Cout = 1'b0; MDR_out = 1'b0; InPort_Out = 1'b0;
    enableMAR = 1'b0; enableMDR = 1'b0; enableIR = 1'b0; enableY = 1'b0;
    enableZ = 1'b0; enablePC = 1'b0; enableHI = 1'b0; enableLO = 1'b0;
    enableInPort = 1'b0; enableOutPort = 1'b0; IncPC = 1'b0; Read = 1'b0;
    RAM_write_enable = 1'b0; conIn = 1'b0; Gra = 1'b0; Grb = 1'b0;
    Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    opcode = op_s;
    case (state_q)
      S_RESET: opcode = 5'b00000;
      S_F0: begin run = 1'b1; PCout = 1'b1; enableMAR = 1'b1; IncPC = 1'b1; end
      S_F1: begin run = 1'b1; Read = 1'b1; end
      S_F2: begin run = 1'b1; Read = 1'b1; enableMDR = 1'b1; end
      S_F3: begin run = 1'b1; MDR_out = 1'b1; enableIR = 1'b1; end
      S_E0, S_E1, S_E2, S_E3, S_E4, S_E5: begin
        run = 1'b1;
        case (op_s)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL:
            case (e_idx_s)
              3'd0:    begin Grb = 1'b1; Rout = 1'b1; enableY = 1'b1; end
              3'd1:    begin Grc = 1'b1; Rout = 1'b1; enableZ = 1'b1; end
              3'd2:    begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              default: run = 1'b1;
            endcase
          OP_NEG, OP_NOT:
            case (e_idx_s)
              3'd0:    begin Grb = 1'b1; Rout = 1'b1; enableZ = 1'b1; end
              3'd1:    begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              default: run = 1'b1;
            endcase
          OP_ADDI, OP_ANDI, OP_ORI:
            case (e_idx_s)
              3'd0:    begin Grb = 1'b1; Rout = 1'b1; enableY = 1'b1; end
              3'd1:    begin Cout = 1'b1; enableZ = 1'b1; end
              3'd2:    begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              default: run = 1'b1;
            endcase
          OP_LD, OP_LDI, OP_ST:
            case (e_idx_s)
              3'd0: begin Grb = 1'b1; BAout = 1'b1; Rout = 1'b1; enableY = 1'b1; end
              3'd1: begin Cout = 1'b1; opcode = OP_ADD; enableZ = 1'b1; end
              3'd2: begin
                Zlowout = 1'b1;
                if (op_s == OP_LDI) begin
                  Gra = 1'b1; Rin = 1'b1;
                end else begin
                  enableMAR = 1'b1;
                end
              end
              3'd3: begin
                if (op_s == OP_LD) begin
                  Read = 1'b1;
                end else begin
                  Gra = 1'b1; Rout = 1'b1; enableMDR = 1'b1;
                end
              end
              3'd4: begin
                if (op_s == OP_LD) begin
                  Read = 1'b1; enableMDR = 1'b1;
                end else begin
                  RAM_write_enable = 1'b1;
                end
              end
              3'd5:    begin MDR_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              default: run = 1'b1;
            endcase
          OP_MUL, OP_DIV:
            case (e_idx_s)
              3'd0:    begin Gra = 1'b1; Rout = 1'b1; enableY = 1'b1; end
              3'd1:    begin Grb = 1'b1; Rout = 1'b1; enableZ = 1'b1; end
              3'd2:    begin Zlowout = 1'b1; enableLO = 1'b1; end
              3'd3:    begin Zhighout = 1'b1; enableHI = 1'b1; end
              default: run = 1'b1;
            endcase
          OP_BR:
            case (e_idx_s)
              3'd0:    begin Gra = 1'b1; Rout = 1'b1; conIn = 1'b1; end
              3'd1:    begin PCout = 1'b1; enableY = 1'b1; end
              3'd2:    begin Cout = 1'b1; opcode = OP_ADD; enableZ = 1'b1; end
              3'd3:    begin Zlowout = 1'b1; enablePC = con_ff; end
              default: run = 1'b1;
            endcase
          OP_JR: begin
            if (e_idx_s == 3'd0) begin
              Gra = 1'b1; Rout = 1'b1; enablePC = 1'b1;
            end else begin
              run = 1'b1;
            end
          end
          OP_JAL:
            case (e_idx_s)
              3'd0:    begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
              3'd1:    begin Gra = 1'b1; Rout = 1'b1; enablePC = 1'b1; end
              default: run = 1'b1;
            endcase
          OP_IN:
            case (e_idx_s)
              3'd0:    enableInPort = 1'b1;
              3'd1:    begin InPort_Out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              default: run = 1'b1;
            endcase
          OP_OUT: begin
            if (e_idx_s == 3'd0) begin
              Gra = 1'b1; Rout = 1'b1; enableOutPort = 1'b1;
            end else begin
              run = 1'b1;
            end
          end
          OP_MFHI: begin
            if (e_idx_s == 3'd0) begin
              HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end else begin
              run = 1'b1;
            end
          end
          OP_MFLO: begin
            if (e_idx_s == 3'd0) begin
              LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end else begin
              run = 1'b1;
            end
          end
          default: run = 1'b1;
        endcase
      end
      default: run = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed and randomized checks of control_unit against a
// step-counting behavioural model of the micro-sequence tables.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        clear, con_ff, stop;
  logic [31:0] IR;
  logic run, PCout, Zhighout, Zlowout, HIout, LOout, Cout, MDR_out, InPort_Out;
  logic enableMAR, enableMDR, enableIR, enableY, enableZ, enablePC, enableHI;
  logic enableLO, enableInPort, enableOutPort, IncPC, Read, RAM_write_enable;
  logic conIn, Gra, Grb, Grc, Rin, Rout, BAout;
  logic [4:0] opcode;

  always #5 clock = ~clock;

  control_unit dut (
    .clock(clock), .clear(clear), .IR(IR), .con_ff(con_ff), .stop(stop),
    .run(run), .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .HIout(HIout), .LOout(LOout), .Cout(Cout), .MDR_out(MDR_out),
    .InPort_Out(InPort_Out), .enableMAR(enableMAR), .enableMDR(enableMDR),
    .enableIR(enableIR), .enableY(enableY), .enableZ(enableZ),
    .enablePC(enablePC), .enableHI(enableHI), .enableLO(enableLO),
    .enableInPort(enableInPort), .enableOutPort(enableOutPort),
    .IncPC(IncPC), .Read(Read), .RAM_write_enable(RAM_write_enable),
    .conIn(conIn), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .opcode(opcode)
  );

  // Packed view of all strobes, bit n = one named strobe.
  logic [27:0] act;
  assign act = {BAout, Rout, Rin, Grc, Grb, Gra, conIn, RAM_write_enable, Read,
                IncPC, enableOutPort, enableInPort, enableLO, enableHI, enablePC,
                enableZ, enableY, enableIR, enableMDR, enableMAR, InPort_Out,
                MDR_out, Cout, LOout, HIout, Zlowout, Zhighout, PCout};

  localparam logic [27:0] K1 = 28'd1;
  localparam logic [27:0] PCO = K1 << 0,  ZHO = K1 << 1,  ZLO = K1 << 2,  HIO = K1 << 3;
  localparam logic [27:0] LOO = K1 << 4,  CO  = K1 << 5,  MDO = K1 << 6,  IPO = K1 << 7;
  localparam logic [27:0] EMAR = K1 << 8, EMDR = K1 << 9, EIR = K1 << 10, EY = K1 << 11;
  localparam logic [27:0] EZ = K1 << 12,  EPC = K1 << 13, EHI = K1 << 14, ELO = K1 << 15;
  localparam logic [27:0] EIN = K1 << 16, EOUT = K1 << 17, INC = K1 << 18, RD = K1 << 19;
  localparam logic [27:0] WR = K1 << 20,  CIN = K1 << 21, GA = K1 << 22,  GB = K1 << 23;
  localparam logic [27:0] GC = K1 << 24,  RI = K1 << 25,  RO = K1 << 26,  BA = K1 << 27;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: mode -1 unknown, 0 reset, 1 fetch, 2 execute, 3 pause, 4 halt.
  int m_mode = -1;
  int m_step = 0;

  function automatic int exec_len(input logic [4:0] op);
    if (op == 5'd0) return 6;
    if (op == 5'd2) return 5;
    if (op == 5'd19 || op == 5'd15 || op == 5'd16) return 4;
    if (op >= 5'd1 && op <= 5'd14) return 3;
    if (op == 5'd17 || op == 5'd18 || op == 5'd20 || op == 5'd22) return 2;
    return 1;
  endfunction

  function automatic logic [27:0] exp_strobes(input int mode, input int s,
                                              input logic [4:0] op, input logic c);
    logic [27:0] t[6];
    for (int i = 0; i < 6; i++) t[i] = 28'd0;
    if (mode == 1) begin
      t[0] = PCO | EMAR | INC; t[1] = RD; t[2] = RD | EMDR; t[3] = MDO | EIR;
      return t[s];
    end
    if (mode != 2) return 28'd0;
    if (op >= 5'd3 && op <= 5'd11) begin
      t[0] = GB | RO | EY; t[1] = GC | RO | EZ; t[2] = ZLO | GA | RI;
    end else if (op >= 5'd12 && op <= 5'd14) begin
      t[0] = GB | RO | EY; t[1] = CO | EZ; t[2] = ZLO | GA | RI;
    end else if (op <= 5'd2) begin
      t[0] = GB | BA | RO | EY; t[1] = CO | EZ;
      if (op == 5'd1) t[2] = ZLO | GA | RI;
      else t[2] = ZLO | EMAR;
      if (op == 5'd0) begin
        t[3] = RD; t[4] = RD | EMDR; t[5] = MDO | GA | RI;
      end else begin
        t[3] = GA | RO | EMDR; t[4] = WR;
      end
    end else if (op == 5'd15 || op == 5'd16) begin
      t[0] = GA | RO | EY; t[1] = GB | RO | EZ; t[2] = ZLO | ELO; t[3] = ZHO | EHI;
    end else if (op == 5'd17 || op == 5'd18) begin
      t[0] = GB | RO | EZ; t[1] = ZLO | GA | RI;
    end else if (op == 5'd19) begin
      t[0] = GA | RO | CIN; t[1] = PCO | EY; t[2] = CO | EZ;
      t[3] = c ? (ZLO | EPC) : ZLO;
    end else if (op == 5'd20) begin
      t[0] = PCO | GB | RI; t[1] = GA | RO | EPC;
    end else if (op == 5'd21) t[0] = GA | RO | EPC;
    else if (op == 5'd22) begin
      t[0] = EIN; t[1] = IPO | GA | RI;
    end else if (op == 5'd23) t[0] = GA | RO | EOUT;
    else if (op == 5'd24) t[0] = LOO | GA | RI;
    else if (op == 5'd25) t[0] = HIO | GA | RI;
    return t[s];
  endfunction

  function automatic logic [4:0] exp_opcode(input int mode, input int s, input logic [4:0] op);
    if (mode == 0) return 5'd0;
    if (mode == 2 && s == 1 && op <= 5'd2) return 5'd3;
    if (mode == 2 && s == 2 && op == 5'd19) return 5'd3;
    return op;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Advance model at the active edge, compare DUT with model on the falling edge.
  task automatic tick();
    logic [4:0] op;
    @(posedge clock);
    op = IR[31:27];
    if (clear) begin
      m_mode = 0; m_step = 0;
    end else if (m_mode == 0 || (m_mode == 3 && !stop)) begin
      m_mode = 1; m_step = 0;
    end else if (m_mode == 1) begin
      if (m_step == 3) begin m_mode = 2; m_step = 0; end
      else m_step++;
    end else if (m_mode == 2) begin
      if (op == 5'd27) m_mode = 4;
      else if (m_step == exec_len(op) - 1) begin m_mode = stop ? 3 : 1; m_step = 0; end
      else m_step++;
    end
    @(negedge clock);
    if (m_mode >= 0) begin
      check("strobes", {4'd0, act}, {4'd0, exp_strobes(m_mode, m_step, IR[31:27], con_ff)});
      check("run", {31'd0, run}, {31'd0, (m_mode == 1 || m_mode == 2)});
      check("opcode", {27'd0, opcode}, {27'd0, exp_opcode(m_mode, m_step, IR[31:27])});
    end
  endtask

  logic [9:0]  rd_hist;
  logic [27:0] v1[4];
  logic [27:0] v0[4];

  initial begin
    clear = 1'b1; stop = 1'b0; con_ff = 1'b0; IR = 32'd0;
    // Reset held for two cycles, then release into F0.
    tick(); tick();
    check("reset_strobes", {4'd0, act}, 32'd0);
    check("reset_run", {31'd0, run}, 32'd0);
    clear = 1'b0;
    tick();
    check("f0_after_reset", {29'd0, PCout, enableMAR, IncPC}, 32'd7);

    // ld R2,0x95: Read high only in F1, F2, E3, E4; 10 cycles total.
    IR = 32'h01000095;
    rd_hist = 10'd0;
    rd_hist[0] = Read;
    for (int i = 1; i < 10; i++) begin
      tick();
      rd_hist[i] = Read;
      if (i == 4) check("ld_e0_baout", {31'd0, BAout}, 32'd1);
      if (i == 5) check("ld_e1_opcode", {27'd0, opcode}, 32'd3);
    end
    check("ld_read_cycles", {22'd0, rd_hist}, 32'h186);
    check("ld_e5", {29'd0, Gra, Rin, MDR_out}, 32'd7);
    tick();
    check("ld_back_to_f0", {31'd0, PCout}, 32'd1);

    // add: three execute steps then F0.
    IR = 32'h18000000;
    repeat (4) tick();
    check("add_e0_y", {31'd0, enableY}, 32'd1);
    tick();
    check("add_e1", {26'd0, enableZ, opcode}, 32'h23);
    tick();
    check("add_e2", {29'd0, Zlowout, Gra, Rin}, 32'd7);
    tick();
    check("add_f0", {31'd0, PCout}, 32'd1);

    // br taken versus not taken.
    IR = {5'b10011, 27'd0};
    con_ff = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 4; i++) begin
      v1[i] = act;
      if (i < 3) tick();
    end
    check("br_taken_pc", {31'd0, enablePC}, 32'd1);
    tick();
    con_ff = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 4; i++) begin
      v0[i] = act;
      if (i < 3) tick();
    end
    check("br_not_taken_pc", {31'd0, enablePC}, 32'd0);
    for (int i = 0; i < 3; i++) check("br_same_steps", {4'd0, v0[i]}, {4'd0, v1[i]});
    check("br_e3_rest", {4'd0, v0[3]}, {4'd0, v1[3] & ~EPC});
    tick();

    // mul: LO then HI.
    IR = {5'b10000, 27'h0012345};
    repeat (6) tick();
    check("mul_e2", {30'd0, enableLO, Zlowout}, 32'd3);
    tick();
    check("mul_e3", {30'd0, enableHI, Zhighout}, 32'd3);
    tick();

    // addi with stop raised in E1: finishes, pauses, resumes.
    IR = {5'b01100, 27'h0000010};
    repeat (5) tick();
    stop = 1'b1;
    tick();
    check("addi_e2", {29'd0, Zlowout, Gra, Rin}, 32'd7);
    tick();
    check("pause_run", {31'd0, run}, 32'd0);
    check("pause_strobes", {4'd0, act}, 32'd0);
    tick(); tick();
    stop = 1'b0;
    tick();
    check("pause_resume_f0", {31'd0, PCout}, 32'd1);

    // halt: held for 20 cycles, then clear restarts.
    IR = {5'b11011, 27'd0};
    repeat (5) tick();
    for (int i = 0; i < 20; i++) begin
      check("halt_run", {31'd0, run}, 32'd0);
      tick();
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    check("halt_restart_f0", {30'd0, PCout, run}, 32'd3);

    // Randomized run against the model.
    for (int i = 0; i < 5000; i++) begin
      tick();
      clear  = ($urandom_range(0, 99) == 0);
      stop   = ($urandom_range(0, 5) == 0);
      con_ff = 1'($urandom_range(0, 1));
      if (m_mode == 1 && m_step == 0) begin
        IR = $urandom;
        if (IR[31:27] == 5'd27 && $urandom_range(0, 3) != 0) IR[31:27] = 5'd0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
